ram_initiator: RTL and testbench
================================

RAM_INITIATOR -- requirements
Module: ram_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width of the RAM port (4 KiB, 1024 words).
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for i_ack before flagging an error.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning):
  i_clk  in  1  clock
  i_rst  in  1  asynchronous active-high reset
  i_req_valid  in  1  core request present
  o_req_ready  out  1  request accepted when valid & ready
  i_req_we  in  1  1=store, 0=load
  i_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
  i_req_unsigned  in  1  zero-extend loads
  i_req_addr  in  ADDR_WIDTH  byte address
  i_req_wdata  in  32  store data, right-aligned
  o_rsp_valid  out  1  one-cycle response strobe
  o_rsp_rdata  out  32  load result, extended; 0 for stores and errors
  o_rsp_err  out  1  misaligned, illegal-size or timeout
  o_cs  out  1  RAM chip select
  o_wr_en  out  1  RAM write enable
  o_b_en  out  4  RAM byte enables
  o_wr_data  out  32  RAM write data
  o_addr  out  ADDR_WIDTH  RAM byte address, bits [1:0] forced to 0
  i_ack  in  1  RAM ack, registered, arrives 1 cycle after cs
  i_rd_data  in  32  RAM read word, valid with i_ack

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT, RESP. o_req_ready SHALL be 1 only in IDLE with i_rst low.
REQ-006 IDLE SHALL register the request on valid & ready, then go to RESP with err=1 if the request is illegal or misaligned, else to ISSUE.
  - illegal: size 11
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0
REQ-007 ISSUE SHALL assert o_cs for exactly one cycle and then go to WAIT. In all other states o_cs, o_wr_en, o_b_en and o_wr_data SHALL be 0.
REQ-008 Byte enables in ISSUE SHALL be:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
  - applied identically for loads and stores
REQ-009 Store data SHALL be lane-replicated: byte as {4{wdata[7:0]}}, half as {2{wdata[15:0]}}, word as-is.
REQ-010 WAIT SHALL sample i_ack every cycle. When ack=1 it SHALL capture i_rd_data and go to RESP with err=0.
REQ-011 A WAIT cycle counter SHALL start at 0. If it reaches TIMEOUT with no ack, the FSM SHALL go to RESP with err=1 and rdata=0.
REQ-012 Load extraction SHALL select the byte or half at addr[1:0], then sign-extend it (or zero-extend if i_req_unsigned=1). A word load SHALL pass i_rd_data through.
REQ-013 RESP SHALL hold o_rsp_valid=1 for one cycle with registered rdata and err, then return to IDLE. There is no backpressure on the response.
REQ-014 Latency SHALL be accept at T, o_cs at T+1, ack at T+2, o_rsp_valid at T+3. An error detected in IDLE SHALL give o_rsp_valid at T+1.
REQ-015 i_ack seen outside WAIT SHALL be ignored.
REQ-016 i_req_* SHALL be ignored unless valid & ready. Only one transaction SHALL be outstanding at a time.

Reset
REQ-017 While i_rst=1 the block SHALL asynchronously force:
  - state IDLE, counter 0
  - all captured request and response registers cleared
  - o_req_ready, o_rsp_valid, o_rsp_err, o_cs, o_wr_en = 0
  - o_b_en, o_wr_data, o_addr, o_rsp_rdata = 0
REQ-018 Reset asserted mid-transaction SHALL abort it with no response. The first request after release SHALL be accepted normally.

Structure
REQ-019 Package ram_if_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-020 Sub-module ram_lane_align (combinational) SHALL compute byte enables, write-data replication, load extraction/extension and the misalign check. ram_initiator SHALL hold the FSM, counter and registers.

Verification
REQ-021 Word store 0xDEADBEEF to 0x010, then word load 0x010 -> store: b_en=1111, response err=0, rdata=0; load: rdata=0xDEADBEEF, rsp_valid exactly 3 cycles after accept.
REQ-022 Byte store 0x80 to 0x013, then signed byte load 0x013 and unsigned byte load 0x013 -> store: b_en=1000, wr_data=0x80808080; loads: rdata 0xFFFFFF80 (signed) and 0x00000080 (unsigned).
REQ-023 Half load from 0x001, word load from 0x006, size=11 -> each: no o_cs, err=1, rsp_valid 1 cycle after accept.
REQ-024 RAM model never acks -> err=1 and rdata=0 after TIMEOUT WAIT cycles; ready returns next cycle.
REQ-025 Reset asserted during WAIT -> all outputs 0 immediately and no rsp_valid; next load after release completes correctly.
REQ-026 Back-to-back valid held high for 4 loads, with spurious i_ack pulses in IDLE -> exactly 4 responses in order with correct data; spurious acks ignored.

Source files
------------

// File: rtl/ram_if_pkg.sv
// Shared encodings for the RAM initiator: request size codes, FSM states
// and the legality check for a request's size/alignment.
package ram_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // True when the request can never reach the RAM: illegal size code or
  // an address not aligned to the access size.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_initiator_if.sv
// Core-request / response / RAM-port bundle of the RAM initiator.
// master: the initiator itself; slave: the core and RAM around it.
interface ram_initiator_if #(
  parameter int ADDR_WIDTH = 12
);

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [1:0]            i_req_size;
  logic                  i_req_unsigned;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [31:0]           i_req_wdata;
  logic                  o_rsp_valid;
  logic [31:0]           o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_cs;
  logic                  o_wr_en;
  logic [3:0]            o_b_en;
  logic [31:0]           o_wr_data;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  i_ack;
  logic [31:0]           i_rd_data;

  modport master (
    input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr,
           i_req_wdata, i_ack, i_rd_data,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_cs, o_wr_en, o_b_en, o_wr_data, o_addr
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr,
           i_req_wdata, i_ack, i_rd_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_cs, o_wr_en, o_b_en, o_wr_data, o_addr
  );

endinterface

// File: rtl/ram_lane_align.sv
// Combinational lane steering: byte enables and write-data replication for
// the captured request, load extraction/extension from the RAM word, and
// the size/alignment check on the incoming request.
module ram_lane_align
  import ram_if_pkg::*;
(
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr_lo,
  output logic        chk_bad,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_data,
  output logic [3:0]  b_en,
  output logic [31:0] wr_data,
  output logic [31:0] rd_ext
);

  logic [31:0] rd_shift;

  assign chk_bad  = req_bad(chk_size, chk_addr_lo);
  // Bring the addressed byte/half down to bit 0 before extension.
  assign rd_shift = rd_data >> {addr_lo, 3'b000};

  // Lane selection and extension per access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    b_en    = '0;
    wr_data = '0;
    rd_ext  = '0;
    case (size)
      SZ_BYTE: begin
        b_en    = 4'b0001 << addr_lo;
        wr_data = {4{wdata[7:0]}};
        rd_ext  = is_unsigned ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      SZ_HALF: begin
        b_en    = 4'b0011 << addr_lo;
        wr_data = {2{wdata[15:0]}};
        rd_ext  = is_unsigned ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      SZ_WORD: begin
        b_en    = 4'b1111;
        wr_data = wdata;
        rd_ext  = rd_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_initiator.sv
// Single-outstanding RAM initiator: accepts a core load/store, issues one
// RAM access, waits for the ack (with timeout) and returns a one-cycle
// response. Misaligned or illegal requests are answered without a RAM access.
module ram_initiator
  import ram_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  ram_initiator_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic                  accept;
  logic                  bad_in;
  logic                  timeout_hit;
  logic [3:0]            lane_b_en;
  logic [31:0]           lane_wr_data;
  logic [31:0]           lane_rd_ext;

  assign accept      = (state == IDLE) && bus.i_req_valid;
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  ram_lane_align u_align (
    .chk_size    (bus.i_req_size),
    .chk_addr_lo (bus.i_req_addr[1:0]),
    .chk_bad     (bad_in),
    .size        (req_size),
    .addr_lo     (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rd_data     (bus.i_rd_data),
    .b_en        (lane_b_en),
    .wr_data     (lane_wr_data),
    .rd_ext      (lane_rd_ext)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and all outputs; RAM strobes only in ISSUE, response only in RESP.
  always_comb begin
    state_nxt       = state;
    bus.o_req_ready = 1'b0;
    bus.o_rsp_valid = 1'b0;
    bus.o_rsp_rdata = '0;
    bus.o_rsp_err   = 1'b0;
    bus.o_cs        = 1'b0;
    bus.o_wr_en     = 1'b0;
    bus.o_b_en      = '0;
    bus.o_wr_data   = '0;
    bus.o_addr      = '0;
    case (state)
      IDLE: begin
        bus.o_req_ready = !i_rst;
        if (bus.i_req_valid) state_nxt = bad_in ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.o_cs      = 1'b1;
        bus.o_wr_en   = req_we;
        bus.o_b_en    = lane_b_en;
        bus.o_wr_data = req_we ? lane_wr_data : 32'h0;
        bus.o_addr    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (bus.i_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        bus.o_rsp_valid = 1'b1;
        bus.o_rsp_rdata = rsp_rdata;
        bus.o_rsp_err   = rsp_err;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: captured request and response data are reset too, so nothing stale survives an abort.
    if (i_rst) begin
      cnt          <= '0;
      req_we       <= 1'b0;
      req_size     <= SZ_BYTE;
      req_unsigned <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            req_we       <= bus.i_req_we;
            req_size     <= bus.i_req_size;
            req_unsigned <= bus.i_req_unsigned;
            req_addr     <= bus.i_req_addr;
            req_wdata    <= bus.i_req_wdata;
            rsp_rdata    <= '0;
            rsp_err      <= bad_in;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (bus.i_ack) begin
            rsp_rdata <= req_we ? 32'h0 : lane_rd_ext;
            rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator with a behavioural RAM that acks one
// cycle after chip select (or never, when muted).
module tb_ram_initiator;
  import ram_if_pkg::*;

  localparam int AW = 12;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_initiator_if #(.ADDR_WIDTH(AW)) bus ();

  ram_initiator #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // RAM model.
  logic [31:0] mem [0:1023];
  logic        ack_q;
  logic        spur = 1'b0;
  logic        mute = 1'b0;
  logic [31:0] rd_q;

  assign bus.i_ack     = ack_q | spur;
  assign bus.i_rd_data = rd_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      rd_q  <= 32'h0;
    end else begin
      ack_q <= bus.o_cs & ~mute;
      if (bus.o_cs) begin
        rd_q <= mem[bus.o_addr[AW-1:2]];
        if (bus.o_wr_en)
          for (int i = 0; i < 4; i++)
            if (bus.o_b_en[i]) mem[bus.o_addr[AW-1:2]][8*i +: 8] <= bus.o_wr_data[8*i +: 8];
      end
    end
  end

  // Results of the last do_req.
  logic [31:0]   r_rdata;
  logic          r_err;
  int            r_lat;
  int            r_cs_cnt;
  logic [3:0]    r_ben;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic          r_post_ready;
  logic          r_post_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; latency counted in cycles after the accept cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata);
    int guard = 0;
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    bus.i_req_addr     = addr;
    bus.i_req_wdata    = wdata;
    while (!bus.o_req_ready && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    bus.i_req_valid    = 1'b0;
    bus.i_req_we       = ~we;
    bus.i_req_size     = 2'b11;
    bus.i_req_unsigned = ~uns;
    bus.i_req_addr     = '1;
    bus.i_req_wdata    = 32'h5A5A_5A5A;
    r_lat    = 1;
    r_cs_cnt = 0;
    r_ben    = '0;
    r_wdata  = '0;
    r_we     = 1'b0;
    r_addr   = '0;
    while (!bus.o_rsp_valid && r_lat < 40) begin
      if (bus.o_cs) begin
        r_cs_cnt++;
        r_ben   = bus.o_b_en;
        r_wdata = bus.o_wr_data;
        r_we    = bus.o_wr_en;
        r_addr  = bus.o_addr;
      end
      tick();
      r_lat++;
    end
    r_rdata = bus.o_rsp_rdata;
    r_err   = bus.o_rsp_err;
    tick();
    r_post_ready = bus.o_req_ready;
    r_post_valid = bus.o_rsp_valid;
  endtask

  task automatic test_reset();
    logic [106:0] obs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_err, bus.o_cs, bus.o_wr_en,
           bus.o_b_en, bus.o_wr_data, bus.o_addr, bus.o_rsp_rdata};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_release: got %b expected 1", bus.o_req_ready);
    end
  endtask

  task automatic test_word();
    do_req(1'b1, SZ_WORD, 1'b0, 12'h010, 32'hDEAD_BEEF);
    checks++;
    if (r_cs_cnt !== 1) begin errors++; $display("FAIL word_store_cs_count: got %0d expected 1", r_cs_cnt); end
    checks++;
    if (r_ben !== 4'b1111) begin errors++; $display("FAIL word_store_b_en: got %b expected 1111", r_ben); end
    checks++;
    if (r_we !== 1'b1) begin errors++; $display("FAIL word_store_wr_en: got %b expected 1", r_we); end
    checks++;
    if (r_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_store_wr_data: got %h expected deadbeef", r_wdata); end
    checks++;
    if (r_addr !== 12'h010) begin errors++; $display("FAIL word_store_addr: got %h expected 010", r_addr); end
    checks++;
    if (r_err !== 1'b0 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL word_store_rsp: got err=%b rdata=%h expected err=0 rdata=0", r_err, r_rdata);
    end
    do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
    checks++;
    if (r_rdata !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
      errors++; $display("FAIL word_load_rsp: got err=%b rdata=%h expected err=0 rdata=deadbeef", r_err, r_rdata);
    end
    checks++;
    if (r_lat !== 3) begin errors++; $display("FAIL word_load_latency: got %0d expected 3", r_lat); end
    checks++;
    if (r_we !== 1'b0) begin errors++; $display("FAIL word_load_wr_en: got %b expected 0", r_we); end
    checks++;
    if (r_post_valid !== 1'b0 || r_post_ready !== 1'b1) begin
      errors++; $display("FAIL word_load_after_rsp: got valid=%b ready=%b expected valid=0 ready=1", r_post_valid, r_post_ready);
    end
  endtask

  task automatic test_byte_half();
    do_req(1'b1, SZ_BYTE, 1'b0, 12'h013, 32'h0000_0080);
    checks++;
    if (r_ben !== 4'b1000) begin errors++; $display("FAIL byte_store_b_en: got %b expected 1000", r_ben); end
    checks++;
    if (r_wdata !== 32'h8080_8080) begin errors++; $display("FAIL byte_store_wr_data: got %h expected 80808080", r_wdata); end
    checks++;
    if (r_addr !== 12'h010) begin errors++; $display("FAIL byte_store_addr: got %h expected 010", r_addr); end
    do_req(1'b0, SZ_BYTE, 1'b0, 12'h013, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFF_FF80 || r_err !== 1'b0) begin
      errors++; $display("FAIL byte_load_signed: got err=%b rdata=%h expected err=0 rdata=ffffff80", r_err, r_rdata);
    end
    checks++;
    if (r_ben !== 4'b1000) begin errors++; $display("FAIL byte_load_b_en: got %b expected 1000", r_ben); end
    do_req(1'b0, SZ_BYTE, 1'b1, 12'h013, 32'h0);
    checks++;
    if (r_rdata !== 32'h0000_0080) begin errors++; $display("FAIL byte_load_unsigned: got %h expected 00000080", r_rdata); end
    // Half store over the upper half: word becomes 0x1234BEEF.
    do_req(1'b1, SZ_HALF, 1'b0, 12'h012, 32'hFFFF_1234);
    checks++;
    if (r_ben !== 4'b1100 || r_wdata !== 32'h1234_1234) begin
      errors++; $display("FAIL half_store_lanes: got b_en=%b wr_data=%h expected b_en=1100 wr_data=12341234", r_ben, r_wdata);
    end
    do_req(1'b0, SZ_HALF, 1'b0, 12'h010, 32'h0);
    checks++;
    if (r_rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL half_load_signed: got %h expected ffffbeef", r_rdata); end
    do_req(1'b0, SZ_HALF, 1'b1, 12'h010, 32'h0);
    checks++;
    if (r_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL half_load_unsigned: got %h expected 0000beef", r_rdata); end
    do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
    checks++;
    if (r_rdata !== 32'h1234_BEEF) begin errors++; $display("FAIL half_word_readback: got %h expected 1234beef", r_rdata); end
  endtask

  task automatic test_illegal();
    logic [1:0]    sz [3]  = '{SZ_HALF, SZ_WORD, 2'b11};
    logic [AW-1:0] ad [3]  = '{12'h001, 12'h006, 12'h000};
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, sz[i], 1'b0, ad[i], 32'h0);
      checks++;
      if (r_cs_cnt !== 0) begin errors++; $display("FAIL illegal_%0d_cs: got %0d expected 0", i, r_cs_cnt); end
      checks++;
      if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
        errors++; $display("FAIL illegal_%0d_rsp: got err=%b rdata=%h expected err=1 rdata=0", i, r_err, r_rdata);
      end
      checks++;
      if (r_lat !== 1) begin errors++; $display("FAIL illegal_%0d_latency: got %0d expected 1", i, r_lat); end
    end
  endtask

  task automatic test_timeout();
    mute = 1'b1;
    do_req(1'b0, SZ_WORD, 1'b0, 12'h010, 32'h0);
    mute = 1'b0;
    checks++;
    if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_rsp: got err=%b rdata=%h expected err=1 rdata=0", r_err, r_rdata);
    end
    checks++;
    if (r_lat !== TO + 2) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", r_lat, TO + 2); end
    checks++;
    if (r_post_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready_next: got %b expected 1", r_post_ready); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    sz  [4] = '{SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BYTE};
    logic          un  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] ad  [4] = '{12'h020, 12'h026, 12'h021, 12'h027};
    logic [31:0]   exp [4] = '{32'h1122_3344, 32'hFFFF_A5B6, 32'h0000_0033, 32'hFFFF_FFA5};
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int extra = 0;
    logic take;
    do_req(1'b1, SZ_WORD, 1'b0, 12'h020, 32'h1122_3344);
    do_req(1'b1, SZ_WORD, 1'b0, 12'h024, 32'hA5B6_C7D8);
    // Spurious acks while idle must not start anything.
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
        errors++; $display("FAIL idle_spurious_ack_%0d: got valid=%b ready=%b expected valid=0 ready=1", i, bus.o_rsp_valid, bus.o_req_ready);
      end
    end
    spur = 1'b0;
    bus.i_req_we       = 1'b0;
    bus.i_req_wdata    = 32'h0;
    bus.i_req_size     = sz[0];
    bus.i_req_unsigned = un[0];
    bus.i_req_addr     = ad[0];
    bus.i_req_valid    = 1'b1;
    while (got < 4 && cyc < 80) begin
      spur = bus.o_req_ready | bus.o_rsp_valid;
      if (bus.o_rsp_valid) begin
        checks++;
        if (bus.o_rsp_rdata !== exp[got] || bus.o_rsp_err !== 1'b0) begin
          errors++; $display("FAIL b2b_rsp_%0d: got err=%b rdata=%h expected err=0 rdata=%h", got, bus.o_rsp_err, bus.o_rsp_rdata, exp[got]);
        end
        got++;
      end
      take = bus.o_req_ready & bus.i_req_valid;
      tick();
      cyc++;
      if (take) begin
        idx++;
        if (idx < 4) begin
          bus.i_req_size     = sz[idx];
          bus.i_req_unsigned = un[idx];
          bus.i_req_addr     = ad[idx];
        end else begin
          bus.i_req_valid = 1'b0;
        end
      end
    end
    spur = 1'b0;
    bus.i_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_rsp_valid) extra++;
      tick();
    end
    checks++;
    if (got !== 4 || extra !== 0) begin
      errors++; $display("FAIL b2b_count: got %0d responses plus %0d extra expected 4 plus 0", got, extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [106:0] obs;
    int seen = 0;
    mute = 1'b1;
    bus.i_req_we    = 1'b0;
    bus.i_req_size  = SZ_WORD;
    bus.i_req_addr  = 12'h020;
    bus.i_req_valid = 1'b1;
    tick();
    bus.i_req_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    obs = {bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_err, bus.o_cs, bus.o_wr_en,
           bus.o_b_en, bus.o_wr_data, bus.o_addr, bus.o_rsp_rdata};
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", obs); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.o_rsp_valid) seen++;
    end
    rst  = 1'b0;
    mute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.o_rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_rsp: got %0d responses expected 0", seen); end
    do_req(1'b0, SZ_WORD, 1'b0, 12'h024, 32'h0);
    checks++;
    if (r_rdata !== 32'hA5B6_C7D8 || r_err !== 1'b0 || r_lat !== 3) begin
      errors++; $display("FAIL mid_reset_next_load: got rdata=%h err=%b lat=%0d expected rdata=a5b6c7d8 err=0 lat=3", r_rdata, r_err, r_lat);
    end
  endtask

  initial begin
    bus.i_req_valid    = 1'b0;
    bus.i_req_we       = 1'b0;
    bus.i_req_size     = SZ_BYTE;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_addr     = '0;
    bus.i_req_wdata    = '0;
    test_reset();
    test_word();
    test_byte_half();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
